// File: rtl/mod_main_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mod_main_pkg
// Description : Shared default geometry for the mod_main register file.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_main_pkg;

  // Default word-address width
  localparam int unsigned C_ADDR_W = 4;
  // Default data width
  localparam int unsigned C_DATA_W = 32;
  // Default number of storage words (full address space)
  localparam int unsigned C_DEPTH  = 2 ** C_ADDR_W;

endpackage : mod_main_pkg
`default_nettype wire

// File: rtl/sram_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sram_regfile
// Description : DEPTH x DATA_W storage array with one synchronous write port
//               and one combinational read port. Asynchronous reset clears
//               every word. No write-through bypass: a write becomes visible
//               only after the clock edge that performs it.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_regfile
  import mod_main_pkg::*;
#(
  parameter int unsigned ADDR_W = C_ADDR_W,
  parameter int unsigned DATA_W = C_DATA_W,
  parameter int unsigned DEPTH  = C_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wen_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next-state: copy current contents, overlay the addressed word on a write
  always_comb begin
    mem_d = mem_q;
    if (wen_i) begin
      mem_d[addr_i] = wdata_i;
    end
  end

  // Storage register; reset wins over any write pending on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Zero-latency read of the stored word, independent of the write enable
  assign rdata_o = mem_q[addr_i];

endmodule : sram_regfile
`default_nettype wire

// File: rtl/mod_main.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mod_main
// Description : Top-level wrapper exposing the s_* slave port of a small
//               single-port register file (sram_regfile).
// Revision    : 1.0 - initial release
// ============================================================================
module mod_main
  import mod_main_pkg::*;
#(
  parameter int unsigned ADDR_W = C_ADDR_W,
  parameter int unsigned DATA_W = C_DATA_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic              s_wen,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata
);

  // Storage array with write port and asynchronous read
  sram_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (s_addr),
    .wen_i   (s_wen),
    .wdata_i (s_wdata),
    .rdata_o (s_rdata)
  );

endmodule : mod_main
`default_nettype wire

// File: tb/tb_mod_main.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mod_main
// Description : Directed self-checking bench for mod_main.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_main;

  logic        clk;
  logic        rst;
  logic [3:0]  s_addr;
  logic        s_wen;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;

  int n_checks;
  int n_fail;

  mod_main dut (
    .clk     (clk),
    .rst     (rst),
    .s_addr  (s_addr),
    .s_wen   (s_wen),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata)
  );

  // Clock starts high so negedges fall on 5, 15, ..., 105 ns
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Reset held from t=0 to 105 ns; every address reads 0, writes ignored
  task automatic test_reset();
    for (int i = 0; i < 16; i++) begin
      s_addr = 4'(i);
      #1;
      n_checks++;
      if (s_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", i, s_rdata, 32'h0);
      end
    end
    // write attempt while in reset must be ignored
    s_addr  = 4'd2;
    s_wen   = 1'b1;
    s_wdata = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    n_checks++;
    if (s_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wen_ignored got=%h exp=%h", s_rdata, 32'h0);
    end
    s_wen = 1'b0;
    #(105 - $time);
    rst = 1'b0;
    #1;
    n_checks++;
    if (s_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_addr2 got=%h exp=%h", s_rdata, 32'h0);
    end
  endtask

  // Write 7=5 then 8=6 back to back, read 7 same cycle, then 8
  task automatic test_write_read();
    @(negedge clk);
    s_addr = 4'd7; s_wen = 1'b1; s_wdata = 32'd5;
    @(negedge clk);
    s_addr = 4'd8; s_wen = 1'b1; s_wdata = 32'd6;
    @(negedge clk);
    s_addr = 4'd7; s_wen = 1'b0;
    #1;
    n_checks++;
    if (s_rdata !== 32'd5) begin
      n_fail++;
      $display("FAIL write_read_addr7 got=%h exp=%h", s_rdata, 32'd5);
    end
    @(negedge clk);
    s_addr = 4'd8;
    #1;
    n_checks++;
    if (s_rdata !== 32'd6) begin
      n_fail++;
      $display("FAIL write_read_addr8 got=%h exp=%h", s_rdata, 32'd6);
    end
  endtask

  // Write data with wen low must not disturb addr 7 over 3 edges
  task automatic test_wen_hold();
    @(negedge clk);
    s_addr = 4'd7; s_wen = 1'b0; s_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (s_rdata !== 32'd5) begin
        n_fail++;
        $display("FAIL wen_hold cycle=%0d got=%h exp=%h", c, s_rdata, 32'd5);
      end
    end
  endtask

  // Old data before the edge, new data after it
  task automatic test_read_during_write();
    @(negedge clk);
    s_addr = 4'd3; s_wen = 1'b1; s_wdata = 32'h11;
    @(negedge clk);
    s_wdata = 32'h22;
    #1;
    n_checks++;
    if (s_rdata !== 32'h11) begin
      n_fail++;
      $display("FAIL rdw_before_edge got=%h exp=%h", s_rdata, 32'h11);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (s_rdata !== 32'h22) begin
      n_fail++;
      $display("FAIL rdw_after_edge got=%h exp=%h", s_rdata, 32'h22);
    end
    @(negedge clk);
    s_wen = 1'b0;
  endtask

  // Fill all 16 words with i*0x01010101 then read back for aliasing
  task automatic test_sweep();
    logic [31:0] exp_v;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_addr = 4'(i); s_wen = 1'b1; s_wdata = 32'(i) * 32'h0101_0101;
    end
    @(negedge clk);
    s_wen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_addr = 4'(i);
      exp_v  = 32'(i) * 32'h0101_0101;
      #1;
      n_checks++;
      if (s_rdata !== exp_v) begin
        n_fail++;
        $display("FAIL sweep addr=%0d got=%h exp=%h", i, s_rdata, exp_v);
      end
    end
  endtask

  // Two consecutive writes to one address keep the later value
  task automatic test_back_to_back();
    @(negedge clk);
    s_addr = 4'd9; s_wen = 1'b1; s_wdata = 32'h0000_0001;
    @(negedge clk);
    s_wdata = 32'h0000_0002;
    @(negedge clk);
    s_wen = 1'b0;
    #1;
    n_checks++;
    if (s_rdata !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL b2b_same_addr got=%h exp=%h", s_rdata, 32'h2);
    end
  endtask

  // Async reset pulse between edges, aborted write, then normal write
  task automatic test_reset_mid();
    @(negedge clk);
    s_addr = 4'd5; s_wen = 1'b1; s_wdata = 32'h0000_DEAD;
    @(negedge clk);
    s_wen = 1'b0;
    #1;
    n_checks++;
    if (s_rdata !== 32'h0000_DEAD) begin
      n_fail++;
      $display("FAIL mid_pre_reset got=%h exp=%h", s_rdata, 32'hDEAD);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (s_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_during_reset got=%h exp=%h", s_rdata, 32'h0);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (s_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_after_reset got=%h exp=%h", s_rdata, 32'h0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (s_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_after_edge got=%h exp=%h", s_rdata, 32'h0);
    end
    // reset across a write cycle aborts the write
    @(negedge clk);
    s_addr = 4'd6; s_wen = 1'b1; s_wdata = 32'h0000_BEEF;
    #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; s_wen = 1'b0;
    #1;
    n_checks++;
    if (s_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL aborted_write got=%h exp=%h", s_rdata, 32'h0);
    end
    // first write after reset behaves normally
    @(negedge clk);
    s_wen = 1'b1; s_wdata = 32'h0000_1234;
    @(negedge clk);
    s_wen = 1'b0;
    #1;
    n_checks++;
    if (s_rdata !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL first_write_after_reset got=%h exp=%h", s_rdata, 32'h1234);
    end
    // earlier sweep data must be gone after reset
    s_addr = 4'd15;
    #1;
    n_checks++;
    if (s_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cleared_addr15 got=%h exp=%h", s_rdata, 32'h0);
    end
  endtask

  // Scenario sequence
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    s_addr   = '0;
    s_wen    = 1'b0;
    s_wdata  = '0;
    test_reset();
    test_write_read();
    test_wen_hold();
    test_read_during_write();
    test_back_to_back();
    test_sweep();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mod_main
`default_nettype wire
